mem_arbiter_6502: RTL

MEM_ARBITER_6502 -- requirements
Module: mem_arbiter_6502

---
 rtl/mem_arbiter_6502.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_arbiter_6502.sv
// Shares one SRAM between a 6502-style CPU and a DMA requester. Each bus cycle is
// two clocks: phase 0 clocks the CPU, phase 1 clocks the SRAM.
module mem_arbiter_6502 #(
    parameter int unsigned MAX_DMA_BURST = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [15:0] cpu_address,
    input  logic        cpu_read_not_write,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_ba,
    output logic        cpu_ready,
    output logic        cpu_clk_enable,
    output logic [7:0]  cpu_data_in,

    input  logic        dma_req,
    input  logic [15:0] dma_address,
    input  logic        dma_read_not_write,
    input  logic [7:0]  dma_write_data,
    output logic        dma_ack,
    output logic        dma_read_valid,
    output logic [7:0]  dma_read_data,

    output logic        sram_clk_enable,
    output logic        sram_select,
    output logic [15:0] sram_address,
    output logic        sram_read_not_write,
    output logic        sram_write_enable,
    output logic [7:0]  sram_write_data,
    input  logic [7:0]  sram_read_data
);

    typedef enum logic [1:0] {
        CPU_OWN,
        DMA_WAIT,
        DMA_OWN
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_DMA_BURST);

    state_t      state_q, state_d;
    logic        phase_q;
    logic [3:0]  burst_q, burst_d;
    logic        rd_valid_q;
    logic [7:0]  rd_data_q;
    logic        dma_owns;
    logic        grant;

    assign dma_owns = (state_q == DMA_OWN);
    assign grant    = dma_owns & phase_q;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            CPU_OWN: begin
                burst_d = '0;
                if (dma_req) state_d = DMA_WAIT;
            end
            DMA_WAIT: begin
                // ba stays low through CPU write cycles, so the wait can last several bus cycles
                if (!dma_req) begin
                    state_d = CPU_OWN;
                    burst_d = '0;
                end else if (cpu_ba) begin
                    state_d = DMA_OWN;
                end
            end
            DMA_OWN: begin
                if (!dma_req || (burst_q + 4'd1) == BURST_LIMIT) begin
                    state_d = CPU_OWN;
                    burst_d = '0;
                end else begin
                    burst_d = burst_q + 4'd1;
                end
            end
            default: begin
                state_d = CPU_OWN;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q    <= 1'b0;
            state_q    <= CPU_OWN;
            burst_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            phase_q    <= ~phase_q;
            if (phase_q) begin
                state_q <= state_d;
                burst_q <= burst_d;
            end
            rd_valid_q <= grant & dma_read_not_write;
            if (grant && dma_read_not_write) rd_data_q <= sram_read_data;
        end
    end

    assign cpu_clk_enable      = ~phase_q;
    assign sram_clk_enable     = phase_q;
    assign cpu_ready           = (state_q == CPU_OWN);
    assign cpu_data_in         = sram_read_data;

    assign dma_ack             = grant;
    assign dma_read_valid      = rd_valid_q;
    assign dma_read_data       = rd_data_q;

    assign sram_select         = 1'b1;
    assign sram_address        = dma_owns ? dma_address        : cpu_address;
    assign sram_read_not_write = dma_owns ? dma_read_not_write : cpu_read_not_write;
    assign sram_write_data     = dma_owns ? dma_write_data     : cpu_data_out;
    assign sram_write_enable   = ~sram_read_not_write;

endmodule
